// File: rtl/bus_cycle_ctl.sv
// bus_cycle_ctl
// Sequences CPU memory and I/O bus cycles: AR load, address setup, space and
// direction strobes, optional wait-state stretching with timeout, and recovery.
// A halt/DMA/front-panel requester can take the bus between transactions.
// All outputs are registered decodes of the current state, so every output
// lags the state register by one clock and has no combinational input path.
module bus_cycle_ctl #(
   parameter int ADDR_SETUP    = 1,   // 1..7
   parameter int STROBE_CYCLES = 2,   // 1..15
   parameter int MAX_WAIT      = 15   // 1..255
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic is_io,
   input  logic is_write,
   input  logic nwaiting,
   input  logic halt_req,
   output logic busy,
   output logic done,
   output logic buserr,
   output logic nwrite_ar,
   output logic nmem,
   output logic nio,
   output logic nr,
   output logic nw,
   output logic halt,
   output logic halt_ack
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_SETUP   = 3'd2,
      S_STROBE  = 3'd3,
      S_WAIT    = 3'd4,
      S_RECOVER = 3'd5,
      S_HALTED  = 3'd6
   } state_t;

   localparam logic [3:0] SETUP_LAST  = 4'(ADDR_SETUP - 1);
   localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
   localparam logic [8:0] WAIT_LIMIT  = 9'(MAX_WAIT);

   state_t     state_reg, state_next;
   logic [3:0] phase_cnt_reg;   // cycles spent so far in SETUP or STROBE
   logic [7:0] wait_cnt_reg;    // wait cycles already completed in WAIT
   logic       err_reg;         // wait timeout seen in this transaction
   logic       io_reg;          // latched space select
   logic       wr_reg;          // latched direction

   logic busy_reg, done_reg, buserr_reg, nwrite_ar_reg;
   logic nmem_reg, nio_reg, nr_reg, nw_reg, halt_reg, halt_ack_reg;
   logic busy_next, done_next, buserr_next, nwrite_ar_next;
   logic nmem_next, nio_next, nr_next, nw_next, halt_next, halt_ack_next;

   // Compare one ahead in 9 bits so MAX_WAIT=255 cannot wrap the counter.
   logic wait_hit;
   assign wait_hit = ({1'b0, wait_cnt_reg} + 9'd1) >= WAIT_LIMIT;

   // State register plus per-transaction counters and latched attributes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         phase_cnt_reg <= '0;
         wait_cnt_reg  <= '0;
         err_reg       <= 1'b0;
         io_reg        <= 1'b0;
         wr_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (state_next == state_reg &&
             (state_reg == S_SETUP || state_reg == S_STROBE))
            phase_cnt_reg <= phase_cnt_reg + 4'd1;
         else
            phase_cnt_reg <= '0;

         if (state_reg == S_WAIT && state_next == S_WAIT)
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
         else
            wait_cnt_reg <= '0;

         if (state_reg == S_WAIT && !nwaiting && wait_hit)
            err_reg <= 1'b1;
         else if (state_reg == S_RECOVER)
            err_reg <= 1'b0;

         // Attributes are captured only on acceptance and ignored afterwards
         if (state_reg == S_IDLE && state_next == S_LOAD) begin
            io_reg <= is_io;
            wr_reg <= is_write;
         end
      end
   end

   // Next-state decision; halt requests are only honoured from IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (halt_req)
               state_next = S_HALTED;
            else if (req)
               state_next = S_LOAD;
         end
         S_LOAD:
            state_next = S_SETUP;
         S_SETUP: begin
            if (phase_cnt_reg == SETUP_LAST)
               state_next = S_STROBE;
         end
         S_STROBE: begin
            if (phase_cnt_reg == STROBE_LAST)
               state_next = nwaiting ? S_RECOVER : S_WAIT;
         end
         S_WAIT: begin
            if (nwaiting || wait_hit)
               state_next = S_RECOVER;
         end
         S_RECOVER:
            state_next = S_IDLE;
         S_HALTED: begin
            if (!halt_req)
               state_next = S_IDLE;
         end
         default:
            state_next = S_IDLE;
      endcase
   end

   // Output decode of the current state, registered below
   always_comb begin
      busy_next      = 1'b0;
      done_next      = 1'b0;
      buserr_next    = 1'b0;
      nwrite_ar_next = 1'b1;
      nmem_next      = 1'b1;
      nio_next       = 1'b1;
      nr_next        = 1'b1;
      nw_next        = 1'b1;
      halt_next      = 1'b0;
      halt_ack_next  = 1'b0;
      case (state_reg)
         S_LOAD: begin
            busy_next      = 1'b1;
            nwrite_ar_next = 1'b0;
         end
         S_SETUP:
            busy_next = 1'b1;
         S_STROBE, S_WAIT: begin
            busy_next = 1'b1;
            nmem_next = io_reg;
            nio_next  = ~io_reg;
            nr_next   = wr_reg;
            nw_next   = ~wr_reg;
         end
         S_RECOVER: begin
            busy_next   = 1'b1;
            done_next   = 1'b1;
            buserr_next = err_reg;
         end
         S_HALTED: begin
            halt_next     = 1'b1;
            halt_ack_next = 1'b1;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

   // Output registers; reset forces every strobe inactive on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         buserr_reg    <= 1'b0;
         nwrite_ar_reg <= 1'b1;
         nmem_reg      <= 1'b1;
         nio_reg       <= 1'b1;
         nr_reg        <= 1'b1;
         nw_reg        <= 1'b1;
         halt_reg      <= 1'b0;
         halt_ack_reg  <= 1'b0;
      end else begin
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         buserr_reg    <= buserr_next;
         nwrite_ar_reg <= nwrite_ar_next;
         nmem_reg      <= nmem_next;
         nio_reg       <= nio_next;
         nr_reg        <= nr_next;
         nw_reg        <= nw_next;
         halt_reg      <= halt_next;
         halt_ack_reg  <= halt_ack_next;
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign buserr    = buserr_reg;
   assign nwrite_ar = nwrite_ar_reg;
   assign nmem      = nmem_reg;
   assign nio       = nio_reg;
   assign nr        = nr_reg;
   assign nw        = nw_reg;
   assign halt      = halt_reg;
   assign halt_ack  = halt_ack_reg;

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// tb_bus_cycle_ctl
// Directed bus-cycle scenarios followed by randomised traffic. A transaction-
// level reference model predicts the output vector every cycle from the
// position inside the current bus cycle.
module tb_bus_cycle_ctl;

   localparam int AS     = 1;
   localparam int SC     = 2;
   localparam int MW     = 4;
   localparam int NTXN   = 2500;
   localparam int BUDGET = 60000;
   // {busy,done,buserr,nwrite_ar,nmem,nio,nr,nw,halt,halt_ack}
   localparam logic [9:0] IDLE_VEC = 10'b000_11111_00;

   logic clk, reset, req, is_io, is_write, nwaiting, halt_req;
   logic busy, done, buserr, nwrite_ar, nmem, nio, nr, nw, halt, halt_ack;
   logic [9:0] dut_vec;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: mode 0 idle, 1 halted, 2 in a bus cycle.
   // m_t is the cycle index inside the bus cycle, m_w the wait states so far.
   int   m_mode = 0;
   int   m_t = 0;
   int   m_w = 0;
   logic m_err = 1'b0;
   logic m_io = 1'b0;
   logic m_wr = 1'b0;
   int   m_acc = 0;
   logic [9:0] exp_vec = IDLE_VEC;
   bit   chk_en = 1'b0;
   int   done_cnt = 0;
   logic inv;

   int acc_base, done_base, cyc, txn_no;

   bus_cycle_ctl #(
      .ADDR_SETUP   (AS),
      .STROBE_CYCLES(SC),
      .MAX_WAIT     (MW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .is_io    (is_io),
      .is_write (is_write),
      .nwaiting (nwaiting),
      .halt_req (halt_req),
      .busy     (busy),
      .done     (done),
      .buserr   (buserr),
      .nwrite_ar(nwrite_ar),
      .nmem     (nmem),
      .nio      (nio),
      .nr       (nr),
      .nw       (nw),
      .halt     (halt),
      .halt_ack (halt_ack)
   );

   assign dut_vec = {busy, done, buserr, nwrite_ar, nmem, nio, nr, nw, halt, halt_ack};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected registered outputs for the model's current position
   function automatic logic [9:0] model_vec();
      logic b = 1'b0, d = 1'b0, e = 1'b0, ar = 1'b1;
      logic sm = 1'b1, si = 1'b1, sr = 1'b1, sw = 1'b1, h = 1'b0, ha = 1'b0;
      int   send = AS + SC + m_w;
      if (m_mode == 1) begin
         h  = 1'b1;
         ha = 1'b1;
      end else if (m_mode == 2) begin
         b = 1'b1;
         if (m_t == 0) ar = 1'b0;
         if (m_t >= AS + 1 && m_t <= send) begin
            sm = m_io;
            si = ~m_io;
            sr = m_wr;
            sw = ~m_wr;
         end
         if (m_t == send + 1) begin
            d = 1'b1;
            e = m_err;
         end
      end
      return {b, d, e, ar, sm, si, sr, sw, h, ha};
   endfunction

   // Reference model: advances once per rising edge from the sampled inputs
   initial forever begin
      @(posedge clk);
      if (reset) begin
         exp_vec = IDLE_VEC;
         m_mode  = 0;
         m_t     = 0;
         m_w     = 0;
         m_err   = 1'b0;
      end else begin
         exp_vec = model_vec();
         case (m_mode)
            0: begin
               if (halt_req) m_mode = 1;
               else if (req) begin
                  m_mode = 2; m_t = 0; m_w = 0; m_err = 1'b0;
                  m_io = is_io; m_wr = is_write;
                  m_acc++;
               end
            end
            1: if (!halt_req) m_mode = 0;
            default: begin
               if (m_t == AS + SC + m_w + 1) m_mode = 0;
               else if (m_t == AS + SC + m_w) begin
                  if (!nwaiting && m_w == MW) m_err = 1'b1;
                  else if (!nwaiting) m_w++;
                  m_t++;
               end else m_t++;
            end
         endcase
      end
   end

   // Per-cycle comparison against the model plus protocol invariants
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check_val("outs", 32'(dut_vec), 32'(exp_vec));
         inv = (!nmem && !nio) || (!nr && !nw) ||
               (!nwrite_ar && (!nmem || !nio || !nr || !nw)) ||
               (halt && !(nwrite_ar && nmem && nio && nr && nw)) ||
               (buserr && !done);
         check_val("invariant", 32'(inv), 32'd0);
         if (done) done_cnt++;
      end
   end

   task automatic idle_gap();
      req = 1'b0;
      halt_req = 1'b0;
      nwaiting = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'(done), 32'd1);
      req = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; is_io = 1'b0; is_write = 1'b0;
      nwaiting = 1'b1; halt_req = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check_val("reset_outs", 32'(dut_vec), 32'(IDLE_VEC));
      reset = 1'b0;
      @(negedge clk);

      // Memory read, no waits
      req = 1'b1; is_io = 1'b0; is_write = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         check_val("rd_nwrite_ar", 32'(nwrite_ar), 32'(k != 1));
         check_val("rd_nmem", 32'(nmem), 32'(!(k == 3 || k == 4)));
         check_val("rd_nr", 32'(nr), 32'(!(k == 3 || k == 4)));
         check_val("rd_nio_nw", 32'({nio, nw}), 32'd3);
         check_val("rd_done", 32'(done), 32'(k == 5));
         check_val("rd_busy", 32'(busy), 32'(k >= 1 && k <= 5));
         if (k == 5) req = 1'b0;
      end
      $display("txn mem_read complete");

      // I/O write with three wait states; attributes changed after acceptance
      idle_gap();
      req = 1'b1; is_io = 1'b1; is_write = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         check_val("iow_nio", 32'(nio), 32'(!(k >= 3 && k <= 7)));
         check_val("iow_nw", 32'(nw), 32'(!(k >= 3 && k <= 7)));
         check_val("iow_nmem_nr", 32'({nmem, nr}), 32'd3);
         check_val("iow_done", 32'(done), 32'(k == 8));
         check_val("iow_buserr", 32'(buserr), 32'd0);
         if (k == 1) begin is_io = 1'b0; is_write = 1'b0; end
         nwaiting = !(k >= 3 && k <= 5);
         if (k == 8) req = 1'b0;
      end
      $display("txn io_write_3wait complete");

      // Wait timeout
      idle_gap();
      req = 1'b1; is_io = 1'b0; is_write = 1'b0; nwaiting = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         check_val("to_nmem", 32'(nmem), 32'(!(k >= 3 && k <= 8)));
         check_val("to_done", 32'(done), 32'(k == 9));
         check_val("to_buserr", 32'(buserr), 32'(k == 9));
         check_val("to_busy", 32'(busy), 32'(k >= 1 && k <= 9));
         if (k == 9) req = 1'b0;
      end
      nwaiting = 1'b1;
      $display("txn timeout complete");

      // Simultaneous req and halt_req
      idle_gap();
      req = 1'b1; halt_req = 1'b1; is_io = 1'b0; is_write = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         check_val("hlt_halt", 32'(halt), 32'(k >= 1 && k <= 10));
         check_val("hlt_ack", 32'(halt_ack), 32'(k >= 1 && k <= 10));
         check_val("hlt_nwrite_ar", 32'(nwrite_ar), 32'(k != 12));
         check_val("hlt_nmem_nw", 32'({nmem, nw}), 32'd3);
         check_val("hlt_busy", 32'(busy), 32'(k == 12));
         if (k == 9) halt_req = 1'b0;
      end
      wait_done("hlt_done");
      $display("txn halt_then_write complete");

      // Reset during STROBE of a memory write
      idle_gap();
      req = 1'b1; is_io = 1'b0; is_write = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k == 3) begin
            check_val("rst_strobe_on", 32'({nmem, nw}), 32'd0);
            reset = 1'b1;
         end
         if (k == 4) begin
            check_val("rst_strobe_off", 32'({nmem, nw}), 32'd3);
            check_val("rst_busy", 32'(busy), 32'd0);
            check_val("rst_done", 32'(done), 32'd0);
            reset = 1'b0;
         end
         if (k == 5) check_val("rst_no_done", 32'({busy, done}), 32'd0);
         if (k == 6) check_val("rst_reload", 32'({busy, nwrite_ar}), 32'b10);
      end
      wait_done("rst_done_after");
      $display("txn reset_mid_write complete");

      // Randomised traffic
      idle_gap();
      acc_base  = m_acc;
      done_base = done_cnt;
      cyc = 0;
      txn_no = 0;
      while ((done_cnt - done_base) < NTXN && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            txn_no++;
            $display("txn %0d io=%0b wr=%0b buserr=%0b", txn_no, m_io, m_wr, buserr);
            req = ($urandom_range(0, 3) == 0);
         end else if (!req) begin
            req = ($urandom_range(0, 2) == 0);
         end
         is_io    = 1'($urandom_range(0, 1));
         is_write = 1'($urandom_range(0, 1));
         nwaiting = ($urandom_range(0, 3) != 0);
         if (halt_req) halt_req = ($urandom_range(0, 3) != 0);
         else          halt_req = ($urandom_range(0, 31) == 0);
      end
      check_val("rand_budget", 32'(cyc < BUDGET), 32'd1);
      req = 1'b0; halt_req = 1'b0; nwaiting = 1'b1;
      repeat (40) @(negedge clk);
      check_val("done_count", 32'(done_cnt - done_base), 32'(m_acc - acc_base));
      check_val("idle_end", 32'(dut_vec), 32'(IDLE_VEC));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
